// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU data-bus source mux (sources A..G on Sel 0..6).
package cpu_bus_pkg;

    localparam int unsigned N_SRC = 7;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    localparam logic [SEL_W-1:0] SRC_A = 3'd0;
    localparam logic [SEL_W-1:0] SRC_B = 3'd1;
    localparam logic [SEL_W-1:0] SRC_C = 3'd2;
    localparam logic [SEL_W-1:0] SRC_D = 3'd3;
    localparam logic [SEL_W-1:0] SRC_E = 3'd4;
    localparam logic [SEL_W-1:0] SRC_F = 3'd5;
    localparam logic [SEL_W-1:0] SRC_G = 3'd6;

endpackage

// File: rtl/rr_pick7.sv
// Rotate-priority picker: first requester strictly after Last, wrapping 6 -> 0.
module rr_pick7
    import cpu_bus_pkg::*;
(
    input  logic [N_SRC-1:0] Req,
    input  logic [SEL_W-1:0] Last,
    output logic             Any,
    output logic [SEL_W-1:0] Win
);

    always_comb begin
        logic [SEL_W-1:0] idx;
        logic             found;
        Any   = |Req;
        Win   = '0;
        found = 1'b0;
        idx   = '0;
        // Last itself is visited last, so a repeat winner always has lowest priority.
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            idx = SEL_W'((32'(Last) + k) % N_SRC);
            if (!found && Req[idx]) begin
                Win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin, break-before-make arbiter for the 7-source data-bus mux, with hold timeout.
module bus_source_arbiter #(
    parameter int unsigned N_REQ    = 7,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_REQ-1:0] Req,
    input  logic [N_REQ-1:0] Done,
    output logic [N_REQ-1:0] Grant,
    output logic [SEL_W-1:0] Sel,
    output logic             BusValid,
    output logic             Timeout
);
    import cpu_bus_pkg::arb_state_e;
    import cpu_bus_pkg::IDLE;
    import cpu_bus_pkg::GRANT;
    import cpu_bus_pkg::TURN;
    import cpu_bus_pkg::SRC_A;
    import cpu_bus_pkg::SRC_G;

    localparam int unsigned HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic             valid_q, valid_d;
    logic             tout_q, tout_d;

    logic             any;
    logic [SEL_W-1:0] win;
    logic             done_w, req_w, hold_hit, release_w;

    rr_pick7 u_pick (
        .Req  (Req),
        .Last (last_q),
        .Any  (any),
        .Win  (win)
    );

    // sel_q always names the current owner while in GRANT.
    assign done_w    = Done[sel_q];
    assign req_w     = Req[sel_q];
    assign hold_hit  = (MAX_HOLD != 0) && (hold_q == HC_W'(MAX_HOLD - 1));
    assign release_w = done_w || !req_w || hold_hit;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= SRC_A;
            last_q  <= SRC_G;
            hold_q  <= '0;
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, TURN: state_d = any ? GRANT : IDLE;
            GRANT:      state_d = release_w ? TURN : GRANT;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        tout_d  = 1'b0;
        case (state_q)
            GRANT: begin
                if (release_w) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    tout_d  = hold_hit && !done_w && req_w;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + HC_W'(1);
                end
            end
            default: begin
                if (any) begin
                    grant_d = N_REQ'(1) << win;
                    sel_d   = win;
                    last_d  = win;
                    hold_d  = '0;
                    valid_d = 1'b1;
                end else begin
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
        endcase
    end

    assign Grant    = grant_q;
    assign Sel      = sel_q;
    assign BusValid = valid_q;
    assign Timeout  = tout_q;

    a_onehot:   assert property (@(posedge Clk) disable iff (Reset) $onehot0(grant_q));
    a_valid:    assert property (@(posedge Clk) disable iff (Reset) (grant_q != '0) == valid_q);
    a_sel_hit:  assert property (@(posedge Clk) disable iff (Reset) valid_q |-> grant_q[sel_q]);
    a_sel_rng:  assert property (@(posedge Clk) disable iff (Reset) sel_q <= SEL_W'(N_REQ - 1));

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Scoreboard bench for bus_source_arbiter: directed scenarios plus sticky random traffic.
module tb_bus_source_arbiter;
    import cpu_bus_pkg::*;

    localparam int MAX_HOLD = 15;

    logic       Clk, Reset;
    logic [6:0] Req, Done, Grant;
    logic [2:0] Sel;
    logic       BusValid, Timeout;

    bus_source_arbiter #(.N_REQ(7), .SEL_W(3), .MAX_HOLD(MAX_HOLD)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (Req),
        .Done     (Done),
        .Grant    (Grant),
        .Sel      (Sel),
        .BusValid (BusValid),
        .Timeout  (Timeout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [6:0] g;
        logic [2:0] s;
        logic       v;
        logic       t;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   run_log[$];
    int   tout_seen = 0;
    int   run_len = 0;
    bit   prev_valid = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    // Reference model: who owns the bus, for how many visible cycles, and who won last.
    int m_owner, m_age, m_last, m_sel;
    bit m_tout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic int qat(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_age   = 0;
        m_last  = 6;
        m_sel   = 0;
        m_tout  = 1'b0;
    endfunction

    function automatic void model_step(input logic [6:0] req, input logic [6:0] done);
        m_tout = 1'b0;
        if (m_owner >= 0) begin
            bit by_time;
            by_time = (MAX_HOLD != 0) && (m_age == MAX_HOLD);
            if (done[m_owner] || !req[m_owner] || by_time) begin
                m_tout  = by_time && !done[m_owner] && req[m_owner];
                m_owner = -1;
            end else begin
                m_age++;
            end
        end else begin
            for (int k = 1; k <= 7; k++) begin
                int c;
                c = (m_last + k) % 7;
                if (req[c]) begin
                    m_owner = c;
                    m_age   = 1;
                    m_last  = c;
                    m_sel   = c;
                    break;
                end
            end
        end
    endfunction

    // One clock of stimulus; the owner raises Done once it has held age_lim cycles (if in mask).
    task automatic step(input bit rst, input logic [6:0] req, input logic [6:0] extra,
                        input logic [6:0] mask, input int age_lim);
        logic [6:0] d;
        exp_t       e;
        @(negedge Clk);
        #1;
        d = extra;
        if (m_owner >= 0 && age_lim > 0 && mask[m_owner] && m_age >= age_lim) d[m_owner] = 1'b1;
        Reset = rst;
        Req   = req;
        Done  = d;
        if (rst) model_reset();
        else model_step(req, d);
        e.g = (m_owner >= 0) ? (7'd1 << m_owner) : 7'd0;
        e.s = 3'(m_sel);
        e.v = (m_owner >= 0);
        e.t = m_tout;
        exp_q.push_back(e);
        if (rst) begin
            #1;
            check("rst_async_grant", 32'(Grant), 32'd0);
            check("rst_async_valid", 32'(BusValid), 32'd0);
            check("rst_async_tout", 32'(Timeout), 32'd0);
        end
    endtask

    task automatic clear_logs();
        grant_log.delete();
        run_log.delete();
        tout_seen = 0;
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("cycle{grant,sel,valid,tout}", {20'd0, Grant, Sel, BusValid, Timeout},
                  {20'd0, e.g, e.s, e.v, e.t});
        end
        if (BusValid && !prev_valid) grant_log.push_back(int'(Sel));
        if (BusValid) run_len++;
        else if (prev_valid) begin
            run_log.push_back(run_len);
            run_len = 0;
        end
        if (Timeout) tout_seen++;
        prev_valid = BusValid;
    end

    initial begin
        int   exp_order[8];
        logic [6:0] rq;
        exp_order = '{int'(SRC_A), int'(SRC_B), int'(SRC_C), int'(SRC_D),
                      int'(SRC_E), int'(SRC_F), int'(SRC_G), int'(SRC_A)};
        Reset = 1'b1;
        Req   = '0;
        Done  = '0;
        model_reset();
        repeat (2) @(negedge Clk);
        #2;
        check("reset_grant", 32'(Grant), 32'd0);
        check("reset_sel", 32'(Sel), 32'd0);
        check("reset_valid", 32'(BusValid), 32'd0);
        check("reset_tout", 32'(Timeout), 32'd0);

        // 1: single requester, Done pulse, dead cycle, regrant
        clear_logs();
        step(0, 7'b0000001, 7'b0000000, 7'd0, 0);
        step(0, 7'b0000001, 7'b0000001, 7'd0, 0);
        step(0, 7'b0000001, 7'b0000000, 7'd0, 0);
        step(0, 7'b0000000, 7'b0000000, 7'd0, 0);
        step(0, 7'b0000000, 7'b0000000, 7'd0, 0);
        check("t1_first_sel", 32'(qat(grant_log, 0)), 32'd0);
        check("t1_first_len", 32'(qat(run_log, 0)), 32'd1);
        check("t1_regrant_sel", 32'(qat(grant_log, 1)), 32'd0);

        // 2: everyone requesting, 2-cycle grants in rotation
        step(1, 7'b0, 7'b0, 7'd0, 0);
        clear_logs();
        repeat (25) step(0, 7'b1111111, 7'b0, 7'b1111111, 2);
        step(0, 7'b0, 7'b0, 7'd0, 0);
        step(0, 7'b0, 7'b0, 7'd0, 0);
        for (int i = 0; i < 8; i++) check($sformatf("t2_order%0d", i), 32'(qat(grant_log, i)), 32'(exp_order[i]));
        for (int i = 0; i < 7; i++) check($sformatf("t2_len%0d", i), 32'(qat(run_log, i)), 32'd2);

        // 3: wrap between sources 6 and 0
        step(1, 7'b0, 7'b0, 7'd0, 0);
        clear_logs();
        repeat (6) step(0, 7'b1000001, 7'b0, 7'b1111111, 1);
        step(0, 7'b0, 7'b0, 7'd0, 0);
        check("t3_sel_after_last6", 32'(qat(grant_log, 0)), 32'(SRC_A));
        check("t3_sel_after_last0", 32'(qat(grant_log, 1)), 32'(SRC_G));

        // 4: source 3 never releases and times out; source 5 served next
        clear_logs();
        repeat (21) step(0, 7'b0101000, 7'b0, 7'b0100000, 2);
        step(0, 7'b0, 7'b0, 7'd0, 0);
        step(0, 7'b0, 7'b0, 7'd0, 0);
        check("t4_first_sel", 32'(qat(grant_log, 0)), 32'(SRC_D));
        check("t4_hold_len", 32'(qat(run_log, 0)), 32'(MAX_HOLD));
        check("t4_next_sel", 32'(qat(grant_log, 1)), 32'(SRC_F));
        check("t4_tout_pulses", 32'(tout_seen), 32'd1);

        // 5: Done coincides with the timeout edge; foreign Done ignored
        clear_logs();
        repeat (17) step(0, 7'b0000100, 7'b0010000, 7'b0000100, MAX_HOLD);
        step(0, 7'b0, 7'b0, 7'd0, 0);
        step(0, 7'b0, 7'b0, 7'd0, 0);
        check("t5_sel", 32'(qat(grant_log, 0)), 32'(SRC_C));
        check("t5_len", 32'(qat(run_log, 0)), 32'(MAX_HOLD));
        check("t5_no_tout", 32'(tout_seen), 32'd0);

        // 6: reset while source 5 holds the bus
        clear_logs();
        repeat (4) step(0, 7'b0100000, 7'b0, 7'd0, 0);
        step(1, 7'b0100000, 7'b0, 7'd0, 0);
        repeat (3) step(0, 7'b1100001, 7'b0, 7'b1111111, 1);
        step(0, 7'b0, 7'b0, 7'd0, 0);
        check("t6_before_rst", 32'(qat(grant_log, 0)), 32'(SRC_F));
        check("t6_after_rst", 32'(qat(grant_log, 1)), 32'(SRC_A));

        // random sticky requests, sparse Done, rare resets
        rq = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) rq = 7'($urandom);
            step(($urandom_range(0, 199) == 0), rq, 7'($urandom & $urandom & $urandom), 7'd0, 0);
        end
        step(0, 7'b0, 7'b0, 7'd0, 0);

        @(negedge Clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
